// File: rtl/receive_engine_pkg.sv
// Shared UART definitions: receiver FSM states, frame bit counts and the bit-period width
// that the transmit engine also uses.
package uart_pkg;

  localparam int unsigned BAUD_W = 19;

  localparam logic [3:0] BITS_7 = 4'd7;
  localparam logic [3:0] BITS_8 = 4'd8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    DONE
  } rx_state_t;

  // Number of bits sampled after the start bit: data + optional parity + stop.
  function automatic logic [3:0] frame_bits(input logic eight, input logic pen);
    return (eight ? BITS_8 : BITS_7) + {3'b000, pen} + 4'd1;
  endfunction

endpackage

// File: rtl/receive_engine_if.sv
// Host read port of the UART receive engine: the character, its status flags and the read strobe.
interface receive_engine_if;

  logic       read;
  logic [7:0] rx_data;
  logic       RxRdy;
  logic       PERR;
  logic       FERR;
  logic       OVF;

  modport master (output read, input rx_data, RxRdy, PERR, FERR, OVF);
  modport slave  (input read, output rx_data, RxRdy, PERR, FERR, OVF);

endinterface

// File: rtl/receive_engine_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; presets to the idle (high) level.
module rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/receive_engine.sv
// UART receive engine: deserializes rx into a byte, checks parity/stop and flags it to the host.
// Build option RX_START_CHECK_EN: re-check the start bit at mid-bit and drop false starts.
module receive_engine
  import uart_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic [BAUD_W-1:0] baud_out,
  receive_engine_if.slave   host
);

  localparam logic [BAUD_W-1:0] CNT_ONE = 1;

  logic              rxs;
  logic              rxs_d;
  rx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] cnt_q, cnt_d;
  logic [3:0]        bit_q, bit_d;
  logic [9:0]        shift_q, shift_d;
  logic [3:0]        nbits;
  logic [BAUD_W-1:0] half;
  logic              done;
  logic [7:0]        data_bits;
  logic              par_bit;
  logic              perr;

  rx_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxs)
  );

  assign nbits = frame_bits(eight, pen);
  assign half  = baud_out >> 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      rxs_d   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rxs_d   <= rxs;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Registered falling edge: a line stuck low after a framing error never retriggers.
        if (rxs_d && !rxs) begin
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (cnt_q == half) begin
          cnt_d = '0;
`ifdef RX_START_CHECK_EN
          state_d = rxs ? IDLE : DATA;
`else
          state_d = DATA;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_q == baud_out) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[9:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_d == nbits) state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // The last sampled bit (stop) always sits in shift_q[9]; earlier bits stack below it.
  always_comb begin
    data_bits = '0;
    par_bit   = 1'b0;
    unique case ({eight, pen})
      2'b11: begin data_bits = shift_q[7:0];          par_bit = shift_q[8]; end
      2'b10: begin data_bits = shift_q[8:1];          par_bit = 1'b0;       end
      2'b01: begin data_bits = {1'b0, shift_q[7:1]};  par_bit = shift_q[8]; end
      2'b00: begin data_bits = {1'b0, shift_q[8:2]};  par_bit = 1'b0;       end
    endcase
    perr = pen & (par_bit != ((^data_bits) ^ ohel));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      host.rx_data <= '0;
      host.RxRdy   <= 1'b0;
      host.PERR    <= 1'b0;
      host.FERR    <= 1'b0;
      host.OVF     <= 1'b0;
    end else if (done) begin
      host.rx_data <= data_bits;
      host.PERR    <= perr;
      host.FERR    <= ~shift_q[9];
      host.RxRdy   <= 1'b1;
      host.OVF     <= host.read ? 1'b0 : (host.OVF | host.RxRdy);
    end else if (host.read) begin
      host.RxRdy <= 1'b0;
      host.OVF   <= 1'b0;
    end
  end

endmodule
